// File: rtl/dualram_gen.sv
// Simple dual-port RAM with a single clock, sequenced clear, collision flag and
// optional per-word even parity (enable with `define DUALRAM_PARITY_EN).
module dualram_gen #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              re,
    input  logic              clr,
    input  logic              par_inj,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy,
    output logic              coll,
    output logic              par_err
);

`ifdef DUALRAM_PARITY_EN
    localparam int unsigned WordW = DATA_W + 1;
`else
    localparam int unsigned WordW = DATA_W;
`endif

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    localparam logic [ADDR_W:0]   DepthCmp = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WordW-1:0]  mem [DEPTH];

    logic [DATA_W-1:0] dout_q;
    logic              rd_valid_q;
    logic              coll_q;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              accept;
    logic              wr_ok;
    logic              rd_ok;
    logic              hit;
    logic [WordW-1:0]  wr_word;
    logic [WordW-1:0]  rd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WordW-1:0]  mem_wdata;

    assign wr_in_range = {1'b0, wr_addr} < DepthCmp;
    assign rd_in_range = {1'b0, rd_addr} < DepthCmp;

    // A clr request in READY swallows that cycle's read and write.
    assign accept = (state_q == StReady) && !clr;
    assign wr_ok  = accept && we && wr_in_range;
    assign rd_ok  = accept && re;
    assign hit    = rd_ok && wr_ok && (rd_addr == wr_addr);

`ifdef DUALRAM_PARITY_EN
    assign wr_word = {(^din) ^ par_inj, din};
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign wr_word        = din;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastPtr) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end
            end
            StReady: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    // The clear sequence and user writes share the single memory write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_word;
        if (!rst) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
            end else if (wr_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (hit && (RDW_MODE != 0)) begin
                rd_word = wr_word;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            ptr_q      <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_ok;
            coll_q     <= hit;
            if (rd_ok) begin
                dout_q <= rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef DUALRAM_PARITY_EN
    logic par_err_q;

    // Even parity over data plus stored bit; an all-zero word checks clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (rd_ok) begin
            par_err_q <= ^rd_word;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign coll     = coll_q;
    assign busy     = (state_q == StClear);

endmodule

// File: tb/tb_dualram_gen.sv
// Bench for dualram_gen: a 16-word old-data instance and a 12-word write-through
// instance share directed stimulus and are checked against a behavioural model.
module tb_dualram_gen;

`ifdef DUALRAM_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    localparam int DepA = 16;
    localparam int DepB = 12;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [3:0] wr_addr;
    logic       we;
    logic [3:0] rd_addr;
    logic       re;
    logic       clr;
    logic       par_inj;

    logic [7:0] dout_a, dout_b;
    logic       rd_valid_a, rd_valid_b, busy_a, busy_b, coll_a, coll_b, par_err_a, par_err_b;

    int n_cmp = 0;
    int n_bad = 0;

    dualram_gen #(.DATA_W(8), .ADDR_W(4), .DEPTH(DepA), .RDW_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .wr_addr(wr_addr), .we(we), .rd_addr(rd_addr),
        .re(re), .clr(clr), .par_inj(par_inj), .dout(dout_a), .rd_valid(rd_valid_a),
        .busy(busy_a), .coll(coll_a), .par_err(par_err_a)
    );

    dualram_gen #(.DATA_W(8), .ADDR_W(4), .DEPTH(DepB), .RDW_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .din(din), .wr_addr(wr_addr), .we(we), .rd_addr(rd_addr),
        .re(re), .clr(clr), .par_inj(par_inj), .dout(dout_b), .rd_valid(rd_valid_b),
        .busy(busy_b), .coll(coll_b), .par_err(par_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory contents per instance, remaining busy cycles, expected outputs.
    logic [7:0] m_data [2][16];
    logic       m_par  [2][16];
    int         m_busy [2];
    logic [7:0] e_dout [2];
    logic       e_v    [2];
    logic       e_coll [2];
    logic       e_pe   [2];
    bit         model_on = 1'b0;

    always @(posedge clk) begin : model
        int   dp;
        logic wok;
        logic hit;
        logic [7:0] rd;
        logic       rp;
        for (int i = 0; i < 2; i++) begin
            dp = (i == 0) ? DepA : DepB;
            if (rst) begin
                model_on  = 1'b1;
                m_busy[i] = dp;
                e_dout[i] = 8'h00;
                e_v[i]    = 1'b0;
                e_coll[i] = 1'b0;
                e_pe[i]   = 1'b0;
                for (int a = 0; a < 16; a++) begin
                    m_data[i][a] = 8'h00;
                    m_par[i][a]  = 1'b0;
                end
            end else if (m_busy[i] > 0) begin
                m_busy[i] = m_busy[i] - 1;
                e_v[i]    = 1'b0;
                e_coll[i] = 1'b0;
            end else if (clr) begin
                m_busy[i] = dp;
                e_v[i]    = 1'b0;
                e_coll[i] = 1'b0;
                for (int a = 0; a < 16; a++) begin
                    m_data[i][a] = 8'h00;
                    m_par[i][a]  = 1'b0;
                end
            end else begin
                wok = we && (int'(wr_addr) < dp);
                hit = re && wok && (rd_addr == wr_addr);
                e_v[i]    = re;
                e_coll[i] = hit;
                if (re) begin
                    if (int'(rd_addr) < dp) begin
                        if (hit && i == 1) begin
                            rd = din;
                            rp = (^din) ^ par_inj;
                        end else begin
                            rd = m_data[i][rd_addr];
                            rp = m_par[i][rd_addr];
                        end
                        e_dout[i] = rd;
                        e_pe[i]   = ParEn && (rp != ^rd);
                    end else begin
                        e_dout[i] = 8'h00;
                        e_pe[i]   = 1'b0;
                    end
                end
                if (wok) begin
                    m_data[i][wr_addr] = din;
                    m_par[i][wr_addr]  = (^din) ^ par_inj;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("busy_a", busy_a, m_busy[0] > 0);
            check("dout_a", dout_a, e_dout[0]);
            check("rd_valid_a", rd_valid_a, e_v[0]);
            check("coll_a", coll_a, e_coll[0]);
            check("par_err_a", par_err_a, e_pe[0]);
            check("busy_b", busy_b, m_busy[1] > 0);
            check("dout_b", dout_b, e_dout[1]);
            check("rd_valid_b", rd_valid_b, e_v[1]);
            check("coll_b", coll_b, e_coll[1]);
            check("par_err_b", par_err_b, e_pe[1]);
        end
    end

    // Apply inputs (called at a falling edge), then wait past the next rising edge.
    task automatic tick(input logic r, input logic w, input logic [3:0] wa, input logic [7:0] d,
                        input logic rr, input logic [3:0] ra, input logic c, input logic inj);
        rst = r; we = w; wr_addr = wa; din = d; re = rr; rd_addr = ra; clr = c; par_inj = inj;
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; din = '0; re = 1'b0; rd_addr = '0;
        clr = 1'b0; par_inj = 1'b0;

        // Reset, then the clear sequence
        tick(1'b1, 1'b1, 4'h1, 8'h5A, 1'b1, 4'h1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
        check("rst_busy", busy_a, 1'b1);
        check("rst_dout", dout_a, 8'h00);
        check("rst_valid", rd_valid_a, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            idle();
            check("clr_busy_a", busy_a, k < 16);
            check("clr_busy_b", busy_b, k < 12);
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(k), 1'b0, 1'b0);
            check("zero_dout", dout_a, 8'h00);
            check("zero_valid", rd_valid_a, 1'b1);
        end

        // Basic write then read
        tick(1'b0, 1'b1, 4'hB, 8'hA5, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hB, 1'b0, 1'b0);
        check("basic_dout", dout_a, 8'hA5);
        check("basic_valid", rd_valid_a, 1'b1);
        idle();
        check("basic_hold", dout_a, 8'hA5);
        check("basic_novalid", rd_valid_a, 1'b0);

        // Same-address read during write
        tick(1'b0, 1'b1, 4'h3, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'h3, 8'h22, 1'b1, 4'h3, 1'b0, 1'b0);
        check("coll_old_dout", dout_a, 8'h11);
        check("coll_old_flag", coll_a, 1'b1);
        check("coll_wt_dout", dout_b, 8'h22);
        check("coll_wt_flag", coll_b, 1'b1);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 1'b0, 1'b0);
        check("coll_after", dout_a, 8'h22);
        check("coll_clear", coll_a, 1'b0);

        // Out-of-range on the 12-word instance
        tick(1'b0, 1'b1, 4'hD, 8'h77, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hD, 1'b0, 1'b0);
        check("oor_dout", dout_b, 8'h00);
        check("oor_valid", rd_valid_b, 1'b1);
        check("inr_dout", dout_a, 8'h77);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b0, 1'b0);
        check("oor_alias1", dout_b, 8'h00);
        tick(1'b0, 1'b1, 4'hF, 8'h66, 1'b1, 4'h5, 1'b0, 1'b0);
        check("oor_alias5", dout_b, 8'h00);

        // Parity injection
        tick(1'b0, 1'b1, 4'h5, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0);
        check("par_inj_dout", dout_a, 8'h3C);
        check("par_inj_err", par_err_a, ParEn);
        tick(1'b0, 1'b1, 4'h5, 8'h3C, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0);
        check("par_ok_err", par_err_a, 1'b0);
        tick(1'b0, 1'b1, 4'h5, 8'hC3, 1'b1, 4'h5, 1'b0, 1'b1);
        check("par_wt_err", par_err_b, ParEn);
        check("par_old_err", par_err_a, 1'b0);

        // Fill with FF, then clear with a concurrent write that must be dropped
        for (int k = 0; k < 16; k++) tick(1'b0, 1'b1, 4'(k), 8'hFF, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'h2, 8'hAB, 1'b1, 4'h4, 1'b1, 1'b0);
        check("mclr_busy", busy_a, 1'b1);
        check("mclr_novalid", rd_valid_a, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 1'b1, 4'(k), 8'hEE, 1'b1, 4'(k), 1'b1, 1'b1);
            check("mclr_busy_a", busy_a, k < 16);
        end
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'(k), 1'b0, 1'b0);
            check("mclr_zero", dout_a, 8'h00);
        end

        // Reset in the middle of a clear restarts the full sequence
        tick(1'b0, 1'b1, 4'h6, 8'h99, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h6, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) idle();
        tick(1'b1, 1'b1, 4'h6, 8'h44, 1'b1, 4'h6, 1'b0, 1'b0);
        check("rst_mid_busy", busy_a, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            idle();
            check("rst_mid_busy_a", busy_a, k < 16);
        end

        // Independent read and write on different addresses
        tick(1'b0, 1'b1, 4'h7, 8'h5A, 1'b0, 4'h0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 4'h9, 8'hC6, 1'b1, 4'h7, 1'b0, 1'b0);
        check("indep_dout", dout_a, 8'h5A);
        check("indep_coll", coll_a, 1'b0);
        tick(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 1'b0, 1'b0);
        check("indep_dout2", dout_b, 8'hC6);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
